// File: rtl/pc_next_unit.sv
// Program-counter stage: holds the fetch PC and computes branch, JAL and JALR
// targets. A redirect that arrives during a stall is buffered until the stall
// drops. Fetch freezes on a misaligned target or on a halt request.
module pc_next_unit #(
    parameter int unsigned n        = 32,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic         jump,
    input  logic         jalr,
    input  logic [n-1:0] pc_ex,
    input  logic [n-1:0] offset_shifted,
    input  logic [n-1:0] rs1_val,
    input  logic [n-1:0] imm,
    input  logic         halt,
    output logic [n-1:0] pc_out,
    output logic [n-1:0] pc_plus4,
    output logic         redirect_pending,
    output logic         halted,
    output logic         misaligned
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [n-1:0]   pc_q, pc_d;
    logic [n-1:0]   pend_tgt_q, pend_tgt_d;
    logic           pend_q, pend_d;
    logic           mis_q, mis_d;

    logic           redir;
    logic [n-1:0]   live_tgt;
    logic [n-1:0]   sel_tgt;
    logic           load_req;

    // Live target select: JALR wins over JAL/branch, which share one adder.
    always_comb begin
        redir = jalr | jump | branch_taken;
        if (jalr) begin
            live_tgt = (rs1_val + imm) & {{(n-1){1'b1}}, 1'b0};
        end else begin
            live_tgt = pc_ex + offset_shifted;
        end
        // A live redirect overrides a buffered one when the stall drops.
        load_req = redir | pend_q;
        sel_tgt  = redir ? live_tgt : pend_tgt_q;
    end

    // Next-state logic for the PC, pending buffer, sticky flag and FSM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_d     = pend_q;
        mis_d      = mis_q;
        case (state_q)
            RUN: begin
                if (stall) begin
                    if (redir) begin
                        if (live_tgt[1:0] != 2'b00) begin
                            mis_d   = 1'b1;
                            pend_d  = 1'b0;
                            state_d = HALT;
                        end else begin
                            pend_tgt_d = live_tgt;
                            pend_d     = 1'b1;
                        end
                    end
                end else if (load_req) begin
                    // A redirect flushes the younger halting instruction, so halt is ignored here.
                    pend_d = 1'b0;
                    if (sel_tgt[1:0] != 2'b00) begin
                        mis_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d = sel_tgt;
                    end
                end else if (halt) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + n'(4);
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
            pend_q     <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_q     <= pend_d;
            mis_q      <= mis_d;
        end
    end

    // Output mapping.
    always_comb begin
        pc_out           = pc_q;
        pc_plus4         = pc_q + n'(4);
        redirect_pending = pend_q;
        halted           = (state_q == HALT);
        misaligned       = mis_q;
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: inputs are driven on the falling edge
// with the expected post-edge state pushed to a queue; a monitor pops and
// compares shortly after each rising edge.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch_taken, jump, jalr, halt;
    logic [31:0] pc_ex, offset_shifted, rs1_val, imm;
    logic [31:0] pc_out, pc_plus4;
    logic        redirect_pending, halted, misaligned;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        hlt;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pc_next_unit #(.n(32), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .jump             (jump),
        .jalr             (jalr),
        .pc_ex            (pc_ex),
        .offset_shifted   (offset_shifted),
        .rs1_val          (rs1_val),
        .imm              (imm),
        .halt             (halt),
        .pc_out           (pc_out),
        .pc_plus4         (pc_plus4),
        .redirect_pending (redirect_pending),
        .halted           (halted),
        .misaligned       (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Monitor: compare DUT state just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc_out",           pc_out,                    e.pc);
            check("pc_plus4",         pc_plus4,                  e.pc + 32'd4);
            check("redirect_pending", {31'b0, redirect_pending}, {31'b0, e.pend});
            check("halted",           {31'b0, halted},           {31'b0, e.hlt});
            check("misaligned",       {31'b0, misaligned},       {31'b0, e.mis});
        end
    end

    task automatic idle_inputs();
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jalr = 1'b0; halt = 1'b0;
        pc_ex = '0; offset_shifted = '0; rs1_val = '0; imm = '0;
    endtask

    // Push the expected result of the coming edge and advance to the next falling edge.
    task automatic cyc(input logic [31:0] pc, input logic pend, input logic hlt, input logic mis);
        exp_t e;
        e.pc = pc; e.pend = pend; e.hlt = hlt; e.mis = mis;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_jump(input logic [31:0] tgt);
        idle_inputs();
        jump = 1'b1; pc_ex = tgt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);

        // 1. reset then sequential fetch
        rst = 1'b1; cyc(32'h0, 0, 0, 0);
        rst = 1'b1; cyc(32'h0, 0, 0, 0);
        idle_inputs();
        cyc(32'h4, 0, 0, 0);
        cyc(32'h8, 0, 0, 0);
        cyc(32'hC, 0, 0, 0);

        // 2. branch with wrap-around, then JALR with bit 0 cleared
        idle_inputs(); branch_taken = 1'b1; pc_ex = 32'hFFFF_FFF0; offset_shifted = 32'h20;
        cyc(32'h10, 0, 0, 0);
        idle_inputs(); jalr = 1'b1; rs1_val = 32'h1001; imm = 32'h4;
        cyc(32'h1004, 0, 0, 0);

        // 3. redirect buffered during stall
        set_jump(32'h40); cyc(32'h40, 0, 0, 0);
        set_jump(32'h100); stall = 1'b1; cyc(32'h40, 1, 0, 0);
        idle_inputs(); stall = 1'b1; cyc(32'h40, 1, 0, 0);
        idle_inputs(); stall = 1'b1; cyc(32'h40, 1, 0, 0);
        idle_inputs(); cyc(32'h100, 0, 0, 0);
        // newer redirect in the same stall overwrites the buffer
        set_jump(32'h40); cyc(32'h40, 0, 0, 0);
        set_jump(32'h100); stall = 1'b1; cyc(32'h40, 1, 0, 0);
        set_jump(32'h200); stall = 1'b1; cyc(32'h40, 1, 0, 0);
        idle_inputs(); stall = 1'b1; cyc(32'h40, 1, 0, 0);
        idle_inputs(); cyc(32'h200, 0, 0, 0);

        // 4. live redirect beats pending; jalr beats jump
        set_jump(32'h100); stall = 1'b1; cyc(32'h200, 1, 0, 0);
        idle_inputs(); branch_taken = 1'b1; pc_ex = 32'h300; cyc(32'h300, 0, 0, 0);
        idle_inputs(); cyc(32'h304, 0, 0, 0);
        idle_inputs(); jalr = 1'b1; rs1_val = 32'h500; jump = 1'b1; pc_ex = 32'h600;
        cyc(32'h500, 0, 0, 0);

        // 5. misaligned branch target freezes the unit
        idle_inputs(); branch_taken = 1'b1; pc_ex = 32'h100; offset_shifted = 32'h2;
        cyc(32'h500, 0, 1, 1);
        set_jump(32'h200); cyc(32'h500, 0, 1, 1);
        set_jump(32'h200); stall = 1'b1; cyc(32'h500, 0, 1, 1);
        idle_inputs(); halt = 1'b1; cyc(32'h500, 0, 1, 1);
        // 6a. reset out of HALT with misaligned set
        idle_inputs(); rst = 1'b1; cyc(32'h0, 0, 0, 0);
        // halt request
        set_jump(32'h80); cyc(32'h80, 0, 0, 0);
        idle_inputs(); halt = 1'b1; cyc(32'h80, 0, 1, 0);
        set_jump(32'h300); cyc(32'h80, 0, 1, 0);
        idle_inputs(); rst = 1'b1; cyc(32'h0, 0, 0, 0);
        // halt ignored while stalled
        idle_inputs(); stall = 1'b1; halt = 1'b1; cyc(32'h0, 0, 0, 0);
        idle_inputs(); cyc(32'h4, 0, 0, 0);
        // halt together with a redirect: redirect wins
        set_jump(32'h90); halt = 1'b1; cyc(32'h90, 0, 0, 0);
        idle_inputs(); cyc(32'h94, 0, 0, 0);

        // 6b. reset while a redirect is pending in a stall
        set_jump(32'h100); stall = 1'b1; cyc(32'h94, 1, 0, 0);
        idle_inputs(); stall = 1'b1; rst = 1'b1; cyc(32'h0, 0, 0, 0);
        idle_inputs(); cyc(32'h4, 0, 0, 0);

        // misaligned JALR target captured during a stall halts at once
        idle_inputs(); stall = 1'b1; jalr = 1'b1; rs1_val = 32'h102; cyc(32'h4, 0, 1, 1);
        idle_inputs(); cyc(32'h4, 0, 1, 1);
        idle_inputs(); rst = 1'b1; cyc(32'h0, 0, 0, 0);
        idle_inputs(); cyc(32'h4, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter stage that consumes the left-shifted branch/JAL offset from the one-bit offset shifter and produces the next fetch address.
- Holds the architectural fetch PC, computes branch/JAL/JALR targets, honours hazard stalls, and buffers a redirect that arrives while the PC is stalled.
- Detects misaligned targets and halt requests and freezes fetch.
- Sits between the EX-stage branch decision and the instruction-memory address port.

Parameters:
- n, 32, datapath/address width in bits.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit hold; PC must not advance.
- branch_taken  input  1  conditional branch in EX resolved taken.
- jump  input  1  JAL in EX.
- jalr  input  1  JALR in EX.
- pc_ex  input  n  PC of the EX-stage instruction.
- offset_shifted  input  n  immediate already shifted left by 1, from the shifter.
- rs1_val  input  n  JALR base register value.
- imm  input  n  JALR immediate (unshifted, sign-extended).
- halt  input  1  ECALL/EBREAK halt request from decode.
- pc_out  output  n  registered fetch PC.
- pc_plus4  output  n  pc_out + 4, combinational.
- redirect_pending  output  1  a redirect is buffered during a stall.
- halted  output  1  unit is in HALT.
- misaligned  output  1  sticky; a taken target had target[1:0] != 0.

Behaviour:
- Reset (rst=1 at a clock edge, overriding everything, including mid-stall or in HALT):
  - pc_out = RESET_PC
  - redirect_pending = 0, pending target cleared
  - halted = 0, misaligned = 0
  - state = RUN
- Target arithmetic, modulo 2^n with wrap-around and no overflow flag:
  - Branch/JAL: pc_ex + offset_shifted.
  - JALR: (rs1_val + imm) with bit 0 forced to 0.
- Redirect request (redir) = jalr | jump | branch_taken. Priority if more than one is asserted: jalr > jump > branch_taken.
- States:
  - RUN: normal operation.
  - HALT: entered from RUN; exited only by rst.
- RUN, stall=0, no pending redirect:
  - redir=1 and target aligned: pc_out <= target, next cycle.
  - redir=0: pc_out <= pc_out + 4.
- RUN, stall=1:
  - pc_out holds.
  - If redir=1: pending target <= target and redirect_pending <= 1. A newer redir during the same stall overwrites the buffered target.
- RUN, stall=0, redirect_pending=1:
  - If a live redir is present, the live target wins.
  - Otherwise pc_out <= pending target.
  - redirect_pending <= 0 in either case. A redirect is never lost.
- Misaligned: a target selected for loading with target[1:0] != 0 (checked whether live or pending):
  - pc_out holds.
  - misaligned <= 1, pending cleared, state -> HALT.
  - Target alignment is also checked at capture into the pending buffer. A misaligned capture goes to HALT immediately, even while stalled.
- halt=1 in RUN with stall=0:
  - state -> HALT next edge; pc_out holds.
  - halt together with redir: the redirect has priority and halt is ignored, because the halted instruction is younger and is being flushed.
- HALT:
  - pc_out, misaligned and redirect_pending frozen; all inputs except rst are ignored.
  - halted = 1 (registered, asserted the edge HALT is entered).
- Latency: one cycle from input to pc_out; pc_plus4 tracks pc_out combinationally.

Test Plan:
1. Reset and sequential fetch: rst=1 for 2 cycles, RESET_PC=0 -> pc_out=0; release, no redir -> pc_out 4, 8, 12 on successive edges, pc_plus4 = 8 when pc_out = 4.
2. Taken branch with wrap: pc_ex=0xFFFFFFF0, offset_shifted=0x20, branch_taken=1 -> next pc_out=0x00000010. Repeat with jalr=1, rs1_val=0x1001, imm=0x4 -> pc_out=0x1004 (bit 0 cleared).
3. Redirect during stall: pc_out=0x40, stall=1 for 3 cycles, jump=1 in cycle 1 with target 0x100 -> pc_out stays 0x40 and redirect_pending=1. Drop stall -> pc_out=0x100, pending=0. Variant: second jump to 0x200 in stall cycle 2 -> final pc_out=0x200.
4. Live vs pending: pending target=0x100, stall drops same cycle as branch_taken to 0x300 -> pc_out=0x300, pending cleared. Simultaneous jalr (target 0x500) and jump (0x600) -> pc_out=0x500.
5. Misaligned and halt: branch target 0x102 -> pc_out holds, misaligned=1, halted=1, further redirects and stall toggling ignored. Separately, halt=1 at pc_out=0x80 -> halted=1, pc_out frozen at 0x80; halt with simultaneous jump to 0x90 -> pc_out=0x90, halted=0.
6. Reset mid-operation: in HALT with misaligned=1, and separately with redirect_pending=1 during stall, assert rst -> pc_out=RESET_PC and all flags 0 on the next edge.
